// File: rtl/pipeline_hazard_controller.sv
// Hazard and sequencing control for the five-stage MIPS pipeline.
// Generates stall/flush/bubble/forward controls and handles multi-cycle
// data-memory accesses. If memory never answers, the block traps in a locked
// TIMEOUT state. It also keeps a saturating stall-cycle counter.
module pipeline_hazard_controller #(
  parameter int MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] WriteRegE,
  input  logic [4:0] WriteRegM,
  input  logic [4:0] WriteRegW,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       MemtoRegM,
  input  logic       BranchD,
  input  logic       PCSrcD,
  input  logic       MemAccessM,
  input  logic       MemReadyM,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       BubbleW,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       ForwardAD,
  output logic       ForwardBD,
  output logic       MemTimeout,
  output logic [15:0] StallCycles,
  output logic [1:0] fsm_state
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] TIMEOUT  = 2'd2;

  // Counter value seen during the last memstall cycle before the trap.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  logic [1:0] state;
  logic [1:0] state_next;
  logic [7:0] wait_cnt;
  logic       lwstall;
  logic       brstall;
  logic       memstall;

  // A register match ignores r0, which is never really written.
  function automatic logic hit(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  // Hazard detection terms.
  always_comb begin
    lwstall  = MemtoRegE && RegWriteE && (hit(WriteRegE, RsD) || hit(WriteRegE, RtD));
    brstall  = BranchD &&
               ((RegWriteE && (hit(WriteRegE, RsD) || hit(WriteRegE, RtD))) ||
                (MemtoRegM && (hit(WriteRegM, RsD) || hit(WriteRegM, RtD))));
    memstall = MemAccessM && !MemReadyM;
  end

  // Forwarding muxes: Memory stage wins over WriteBack. Independent of stalls.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    if (!reset) begin
      if (RegWriteM && hit(WriteRegM, RsE))      ForwardAE = 2'b10;
      else if (RegWriteW && hit(WriteRegW, RsE)) ForwardAE = 2'b01;
      if (RegWriteM && hit(WriteRegM, RtE))      ForwardBE = 2'b10;
      else if (RegWriteW && hit(WriteRegW, RtE)) ForwardBE = 2'b01;
      ForwardAD = RegWriteM && hit(WriteRegM, RsD);
      ForwardBD = RegWriteM && hit(WriteRegM, RtD);
    end
  end

  // Next-state logic. The trap fires on the MAX_WAIT-th consecutive memstall
  // cycle. The check also runs in RUN so that MAX_WAIT=1 traps after one cycle.
  always_comb begin
    state_next = state;
    case (state)
      RUN:      if (memstall) state_next = (wait_cnt == WAIT_LAST) ? TIMEOUT : MEM_WAIT;
      MEM_WAIT: if (!memstall) state_next = RUN;
                else if (wait_cnt == WAIT_LAST) state_next = TIMEOUT;
      TIMEOUT:  state_next = TIMEOUT;
      default:  state_next = RUN;
    endcase
  end

  // Pipeline register controls, in priority order.
  always_comb begin
    StallF  = 1'b0;
    StallD  = 1'b0;
    StallE  = 1'b0;
    StallM  = 1'b0;
    FlushD  = 1'b0;
    FlushE  = 1'b0;
    BubbleW = 1'b0;
    if (reset) begin
      StallF = 1'b0;
    end else if (state == TIMEOUT || memstall) begin
      StallF  = 1'b1;
      StallD  = 1'b1;
      StallE  = 1'b1;
      StallM  = 1'b1;
      BubbleW = 1'b1;
    end else if (lwstall || brstall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end else if (PCSrcD) begin
      FlushD = 1'b1;
    end
  end

  // FSM state, wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      wait_cnt   <= 8'd0;
      MemTimeout <= 1'b0;
    end else begin
      state      <= state_next;
      MemTimeout <= (state_next == TIMEOUT);
      if (!memstall)               wait_cnt <= 8'd0;
      else if (wait_cnt != 8'hFF)  wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Saturating count of cycles in which the fetch stage was held.
  always_ff @(posedge clk) begin
    if (reset)                                StallCycles <= 16'd0;
    else if (StallF && StallCycles != 16'hFFFF) StallCycles <= StallCycles + 16'd1;
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller (MAX_WAIT = 4).
module tb_pipeline_hazard_controller;

  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic BranchD, PCSrcD, MemAccessM, MemReadyM;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, BubbleW;
  logic [1:0] ForwardAE, ForwardBE;
  logic ForwardAD, ForwardBD, MemTimeout;
  logic [15:0] StallCycles;
  logic [1:0] fsm_state;

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit m_timed_out;
  bit m_prev_mem;
  int m_run_len;
  int m_cycles;
  logic [6:0] exp_ctl;   // {sf,sd,se,sm,fd,fe,bw}
  logic [5:0] exp_fwd;   // {fae,fbe,fad,fbd}

  pipeline_hazard_controller #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
    .BranchD(BranchD), .PCSrcD(PCSrcD), .MemAccessM(MemAccessM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .BubbleW(BubbleW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .MemTimeout(MemTimeout), .StallCycles(StallCycles), .fsm_state(fsm_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic clear_inputs();
    RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemtoRegE = 0; MemtoRegM = 0;
    BranchD = 0; PCSrcD = 0; MemAccessM = 0; MemReadyM = 1;
  endtask

  function automatic bit same(input logic [4:0] a, input logic [4:0] b);
    return (a != 0) && (a == b);
  endfunction

  function automatic logic [1:0] fwd_e(input logic [4:0] src);
    if (RegWriteM && same(WriteRegM, src)) return 2'b10;
    if (RegWriteW && same(WriteRegW, src)) return 2'b01;
    return 2'b00;
  endfunction

  // Expected combinational outputs from the current inputs and model state.
  task automatic compute();
    bit lw, br, mem;
    lw  = MemtoRegE && RegWriteE && (same(WriteRegE, RsD) || same(WriteRegE, RtD));
    br  = BranchD && ((RegWriteE && (same(WriteRegE, RsD) || same(WriteRegE, RtD))) ||
                      (MemtoRegM && (same(WriteRegM, RsD) || same(WriteRegM, RtD))));
    mem = MemAccessM && !MemReadyM;
    if (reset)                   exp_ctl = 7'b0000000;
    else if (m_timed_out || mem) exp_ctl = 7'b1111001;
    else if (lw || br)           exp_ctl = 7'b1100010;
    else if (PCSrcD)             exp_ctl = 7'b0000100;
    else                         exp_ctl = 7'b0000000;
    if (reset) exp_fwd = 6'b0;
    else exp_fwd = {fwd_e(RsE), fwd_e(RtE),
                    RegWriteM && same(WriteRegM, RsD), RegWriteM && same(WriteRegM, RtD)};
  endtask

  task automatic check_all();
    logic [1:0] exp_state;
    compute();
    exp_state = m_timed_out ? 2'd2 : (m_prev_mem ? 2'd1 : 2'd0);
    chk("ctl", {9'b0, StallF, StallD, StallE, StallM, FlushD, FlushE, BubbleW}, {9'b0, exp_ctl});
    chk("fwd", {10'b0, ForwardAE, ForwardBE, ForwardAD, ForwardBD}, {10'b0, exp_fwd});
    chk("timeout", {15'b0, MemTimeout}, {15'b0, m_timed_out});
    chk("stall_cycles", StallCycles, 16'(m_cycles));
    chk("state", {14'b0, fsm_state}, {14'b0, exp_state});
  endtask

  // Advance one clock edge and the model with it; returns at the next negedge.
  task automatic tick();
    bit mem;
    compute();
    mem = MemAccessM && !MemReadyM;
    @(posedge clk);
    if (reset) begin
      m_timed_out = 0; m_prev_mem = 0; m_run_len = 0; m_cycles = 0;
    end else begin
      if (exp_ctl[6] && m_cycles < 65535) m_cycles++;
      if (mem) begin
        m_run_len++;
        if (m_run_len >= MAX_WAIT) m_timed_out = 1;
      end else begin
        m_run_len = 0;
      end
      m_prev_mem = mem;
    end
    @(negedge clk);
  endtask

  task automatic cycle();
    #1;
    check_all();
    tick();
  endtask

  initial begin
    // Reset
    clear_inputs();
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    m_timed_out = 0; m_prev_mem = 0; m_run_len = 0; m_cycles = 0;
    cycle();
    reset = 0;
    cycle();

    // Forwarding: M priority, then W, then r0 never matches
    RsE = 5; RegWriteM = 1; WriteRegM = 5; RegWriteW = 1; WriteRegW = 5;
    #1 chk("fwdAE_M", {14'b0, ForwardAE}, 16'h2);
    cycle();
    WriteRegM = 0;
    #1 chk("fwdAE_W", {14'b0, ForwardAE}, 16'h1);
    cycle();
    WriteRegW = 0;
    #1 chk("fwdAE_r0", {14'b0, ForwardAE}, 16'h0);
    cycle();

    // Load-use stall for one cycle
    clear_inputs();
    MemtoRegE = 1; RegWriteE = 1; WriteRegE = 8; RtD = 8;
    #1 chk("lw_ctl", {9'b0, StallF, StallD, StallE, StallM, FlushD, FlushE, BubbleW}, 16'h62);
    chk("lw_cnt0", StallCycles, 16'd0);
    cycle();
    clear_inputs();
    #1 chk("lw_cnt1", StallCycles, 16'd1);
    cycle();

    // Branch behind a load, then taken branch with no hazard
    BranchD = 1; RsD = 3; MemtoRegM = 1; WriteRegM = 3;
    #1 chk("br_ctl", {9'b0, StallF, StallD, StallE, StallM, FlushD, FlushE, BubbleW}, 16'h62);
    cycle();
    clear_inputs();
    BranchD = 1; PCSrcD = 1; RsD = 3;
    #1 chk("pcsrc_ctl", {9'b0, StallF, StallD, StallE, StallM, FlushD, FlushE, BubbleW}, 16'h04);
    cycle();

    // Memory wait: three stall cycles then completion
    clear_inputs();
    MemAccessM = 1; MemReadyM = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("mw_ctl", {9'b0, StallF, StallD, StallE, StallM, FlushD, FlushE, BubbleW}, 16'h79);
      cycle();
      chk("mw_state", {14'b0, fsm_state}, 16'd1);
    end
    MemReadyM = 1;
    #1 chk("mw_done_ctl", {9'b0, StallF, StallD, StallE, StallM, FlushD, FlushE, BubbleW}, 16'h00);
    cycle();
    chk("mw_state_run", {14'b0, fsm_state}, 16'd0);
    chk("mw_cycles", StallCycles, 16'd5);

    // Ready on the first access cycle: no stall, stays in RUN
    cycle();
    chk("mw_fast_state", {14'b0, fsm_state}, 16'd0);

    // Timeout after exactly MAX_WAIT stall cycles, then sticky
    MemReadyM = 0;
    for (int i = 0; i < MAX_WAIT; i++) begin
      chk("to_not_yet", {15'b0, MemTimeout}, 16'd0);
      cycle();
    end
    chk("to_set", {15'b0, MemTimeout}, 16'd1);
    MemAccessM = 0; MemReadyM = 1;
    for (int i = 0; i < 3; i++) cycle();
    chk("to_sticky", {15'b0, MemTimeout}, 16'd1);
    chk("to_state", {14'b0, fsm_state}, 16'd2);

    // Reset pulse out of TIMEOUT, with memory still stalling
    MemAccessM = 1; MemReadyM = 0;
    reset = 1;
    #1 chk("rst_ctl", {9'b0, StallF, StallD, StallE, StallM, FlushD, FlushE, BubbleW}, 16'h00);
    cycle();
    reset = 0;
    clear_inputs();
    #1 chk("rst_state", {14'b0, fsm_state}, 16'd0);
    chk("rst_timeout", {15'b0, MemTimeout}, 16'd0);
    chk("rst_cycles", StallCycles, 16'd0);
    cycle();

    // Randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      RsD = 5'($urandom_range(0, 5)); RtD = 5'($urandom_range(0, 5));
      RsE = 5'($urandom_range(0, 5)); RtE = 5'($urandom_range(0, 5));
      WriteRegE = 5'($urandom_range(0, 5));
      WriteRegM = 5'($urandom_range(0, 5));
      WriteRegW = 5'($urandom_range(0, 5));
      RegWriteE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      MemtoRegE = 1'($urandom); MemtoRegM = 1'($urandom);
      BranchD = 1'($urandom); PCSrcD = 1'($urandom);
      MemAccessM = ($urandom_range(0, 3) == 0);
      MemReadyM = ($urandom_range(0, 2) != 0);
      reset = (m_timed_out && $urandom_range(0, 3) == 0) || ($urandom_range(0, 199) == 0);
      cycle();
    end
    reset = 1;
    cycle();
    reset = 0;

    // Saturation: hold a load-use hazard long enough to overflow 16 bits
    clear_inputs();
    MemtoRegE = 1; RegWriteE = 1; WriteRegE = 9; RsD = 9;
    for (int i = 0; i < 65540; i++) tick();
    #1 chk("sat", StallCycles, 16'hFFFF);
    check_all();
    tick();
    tick();
    #1 chk("sat_hold", StallCycles, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
